// File: rtl/hit_pkg.sv
// Shared definitions for the lane-FIFO interface between the hit dispatcher
// and the hit collector.
package hit_pkg;

    localparam int LENGTH_COUNTER  = 8;
    localparam int LENGTH_HIT_INFO = 22;
    localparam int PTR_WIDTH       = 5;

    typedef struct packed {
        logic [LENGTH_COUNTER-1:0] add_inQ;
        logic [LENGTH_COUNTER-1:0] add_inS;
        logic [LENGTH_COUNTER-1:0] length;
    } hit_t;

    typedef logic [PTR_WIDTH-1:0] lane_idx_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } disp_state_t;

endpackage

// File: rtl/rr_lane_select.sv
// Combinational rotating-priority finder: lowest available lane at or above
// rr_ptr, else the lowest available lane overall.
module rr_lane_select #(
    parameter int LANES     = 22,
    parameter int PTR_WIDTH = 5
) (
    input  logic [LANES-1:0]     avail,
    input  logic [PTR_WIDTH-1:0] rr_ptr,
    output logic                 sel_found,
    output logic [PTR_WIDTH-1:0] sel_lane
);

    logic [LANES-1:0]     upper;
    logic [PTR_WIDTH-1:0] upper_idx;
    logic [PTR_WIDTH-1:0] any_idx;

    always_comb begin
        upper     = '0;
        upper_idx = '0;
        any_idx   = '0;
        for (int i = 0; i < LANES; i++) begin
            upper[i] = avail[i] && (PTR_WIDTH'(i) >= rr_ptr);
        end
        // Descending scan so the last write leaves the lowest set index.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (upper[i]) upper_idx = PTR_WIDTH'(i);
            if (avail[i]) any_idx   = PTR_WIDTH'(i);
        end
        sel_found = |avail;
        sel_lane  = (|upper) ? upper_idx : any_idx;
    end

endmodule

// File: rtl/hit_dispatcher.sv
// Round-robin write side of the lane FIFOs: one-entry holding register feeding
// a one-hot wr_en strobe with broadcast data buses.
//
// state    | meaning
// ST_EMPTY | holding register empty, in_ready high
// ST_HELD  | hit waiting for a non-full lane
module hit_dispatcher
    import hit_pkg::disp_state_t;
    import hit_pkg::ST_EMPTY;
    import hit_pkg::ST_HELD;
#(
    parameter int LENGTH_COUNTER  = 8,
    parameter int LENGTH_HIT_INFO = 22,
    parameter int PTR_WIDTH       = 5,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                  com_clk,
    input  logic                                  reset_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [LENGTH_COUNTER-1:0]             in_add_inQ,
    input  logic [LENGTH_COUNTER-1:0]             in_add_inS,
    input  logic [LENGTH_COUNTER-1:0]             in_length,
    input  logic [LENGTH_HIT_INFO-1:0]            lane_full,
    output logic [LENGTH_HIT_INFO-1:0]            wr_en,
    output logic [LENGTH_COUNTER*LENGTH_HIT_INFO-1:0] hit_add_inQ,
    output logic [LENGTH_COUNTER*LENGTH_HIT_INFO-1:0] hit_add_inS,
    output logic [LENGTH_COUNTER*LENGTH_HIT_INFO-1:0] hit_length,
    output logic [CNT_WIDTH-1:0]                  dispatch_count,
    output logic [CNT_WIDTH-1:0]                  stall_count
);

    localparam logic [LENGTH_HIT_INFO-1:0] ONE_HOT_LSB = {{(LENGTH_HIT_INFO-1){1'b0}}, 1'b1};
    localparam logic [PTR_WIDTH-1:0]       LAST_LANE   = PTR_WIDTH'(LENGTH_HIT_INFO - 1);
    localparam logic [CNT_WIDTH-1:0]       CNT_MAX     = {CNT_WIDTH{1'b1}};

    disp_state_t state_q, state_d;

    logic [LENGTH_COUNTER-1:0] hold_q_q, hold_s_q, hold_len_q;
    logic [PTR_WIDTH-1:0]      rr_ptr_q;
    logic [PTR_WIDTH-1:0]      sel_lane;
    logic                      sel_found;
    logic                      hold_valid;
    logic                      dispatch_now;
    logic                      load;

    rr_lane_select #(
        .LANES     (LENGTH_HIT_INFO),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_sel (
        .avail     (~lane_full),
        .rr_ptr    (rr_ptr_q),
        .sel_found (sel_found),
        .sel_lane  (sel_lane)
    );

    assign hold_valid   = (state_q == ST_HELD);
    assign dispatch_now = hold_valid && sel_found;
    assign in_ready     = !hold_valid || dispatch_now;
    // Zero-length hits complete the handshake but never enter the register.
    assign load         = in_valid && in_ready && (in_length != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (load) state_d = ST_HELD;
            ST_HELD:  if (dispatch_now && !load) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge com_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge com_clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q_q       <= '0;
            hold_s_q       <= '0;
            hold_len_q     <= '0;
            rr_ptr_q       <= '0;
            wr_en          <= '0;
            hit_add_inQ    <= '0;
            hit_add_inS    <= '0;
            hit_length     <= '0;
            dispatch_count <= '0;
            stall_count    <= '0;
        end else begin
            if (load) begin
                hold_q_q   <= in_add_inQ;
                hold_s_q   <= in_add_inS;
                hold_len_q <= in_length;
            end
            wr_en <= dispatch_now ? (ONE_HOT_LSB << sel_lane) : '0;
            if (dispatch_now) begin
                hit_add_inQ <= {LENGTH_HIT_INFO{hold_q_q}};
                hit_add_inS <= {LENGTH_HIT_INFO{hold_s_q}};
                hit_length  <= {LENGTH_HIT_INFO{hold_len_q}};
                rr_ptr_q    <= (sel_lane == LAST_LANE) ? '0 : sel_lane + PTR_WIDTH'(1);
                if (dispatch_count != CNT_MAX) dispatch_count <= dispatch_count + CNT_WIDTH'(1);
            end
            if (hold_valid && !sel_found && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_hit_dispatcher.sv
// Directed self-checking bench for hit_dispatcher.
module tb_hit_dispatcher;

    logic          com_clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_add_inQ, in_add_inS, in_length;
    logic [21:0]   lane_full;
    logic [21:0]   wr_en;
    logic [175:0]  hit_add_inQ, hit_add_inS, hit_length;
    logic [15:0]   dispatch_count, stall_count;

    int total = 0;
    int bad   = 0;

    hit_dispatcher dut (
        .com_clk        (com_clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_add_inQ     (in_add_inQ),
        .in_add_inS     (in_add_inS),
        .in_length      (in_length),
        .lane_full      (lane_full),
        .wr_en          (wr_en),
        .hit_add_inQ    (hit_add_inQ),
        .hit_add_inS    (hit_add_inS),
        .hit_length     (hit_length),
        .dispatch_count (dispatch_count),
        .stall_count    (stall_count)
    );

    always #5 com_clk = ~com_clk;

    task automatic tick();
        @(posedge com_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] q, input logic [7:0] s, input logic [7:0] len);
        in_valid   = v;
        in_add_inQ = q;
        in_add_inS = s;
        in_length  = len;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        lane_full = '0;
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        tick();
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_dcount", 32'(dispatch_count), 32'h0);
        chk("rst_scount", 32'(stall_count), 32'h0);
        chk("rst_busq", 32'(hit_add_inQ[31:0]), 32'h0);
        reset_n = 1'b1;

        // Three back-to-back hits, all lanes free
        drive(1'b1, 8'h10, 8'hA0, 8'd5);
        tick();
        chk("b2b_wr0", 32'(wr_en), 32'h0);
        chk("b2b_rdy0", 32'(in_ready), 32'h1);
        drive(1'b1, 8'h11, 8'hA1, 8'd5);
        tick();
        chk("b2b_wr1", 32'(wr_en), 32'h000001);
        chk("b2b_q1", 32'(hit_add_inQ[0 +: 8]), 32'h10);
        chk("b2b_rdy1", 32'(in_ready), 32'h1);
        drive(1'b1, 8'h12, 8'hA2, 8'd5);
        tick();
        chk("b2b_wr2", 32'(wr_en), 32'h000002);
        chk("b2b_q2", 32'(hit_add_inQ[8 +: 8]), 32'h11);
        chk("b2b_rdy2", 32'(in_ready), 32'h1);
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        chk("b2b_wr3", 32'(wr_en), 32'h000004);
        chk("b2b_q3", 32'(hit_add_inQ[16 +: 8]), 32'h12);
        chk("b2b_s3", 32'(hit_add_inS[16 +: 8]), 32'hA2);
        tick();
        chk("b2b_idle", 32'(wr_en), 32'h0);
        chk("b2b_dcount", 32'(dispatch_count), 32'd3);
        chk("b2b_hold_bus", 32'(hit_add_inQ[16 +: 8]), 32'h12);

        // Skip full lanes from rr_ptr = 0
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        lane_full = 22'h00000F;
        drive(1'b1, 8'h20, 8'h21, 8'd1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        chk("skip_wr0", 32'(wr_en), 32'h000010);
        drive(1'b1, 8'h30, 8'h31, 8'd2);
        tick();
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        chk("skip_wr1", 32'(wr_en), 32'h000020);
        chk("skip_len1", 32'(hit_length[40 +: 8]), 32'd2);
        chk("skip_dcount", 32'(dispatch_count), 32'd2);

        // Wrap-around: 23 hits, nothing full
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        lane_full = '0;
        for (int i = 0; i < 23; i++) begin
            drive(1'b1, 8'(i), 8'(8'h80 + i), 8'd7);
            tick();
            chk("wrap_rdy", 32'(in_ready), 32'h1);
            if (i >= 1) chk("wrap_wr", 32'(wr_en), 32'h1 << (i - 1));
        end
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        chk("wrap_last_wr", 32'(wr_en), 32'h000001);
        chk("wrap_last_q", 32'(hit_add_inQ[0 +: 8]), 32'd22);
        chk("wrap_dcount", 32'(dispatch_count), 32'd23);
        chk("wrap_scount", 32'(stall_count), 32'd0);

        // All full for 4 cycles, then lane 7 frees; a second hit waits at the port
        lane_full = '1;
        drive(1'b1, 8'h55, 8'h66, 8'd9);
        tick();
        drive(1'b1, 8'h77, 8'h78, 8'd4);
        chk("full_rdy0", 32'(in_ready), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("full_rdy", 32'(in_ready), 32'h0);
            chk("full_wr", 32'(wr_en), 32'h0);
            chk("full_scount", 32'(stall_count), 32'(k));
        end
        lane_full = 22'h3FFF7F;
        #1;
        chk("free_rdy", 32'(in_ready), 32'h1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        chk("free_wr", 32'(wr_en), 32'h000080);
        chk("free_q", 32'(hit_add_inQ[56 +: 8]), 32'h55);
        chk("free_s", 32'(hit_add_inS[56 +: 8]), 32'h66);
        chk("free_len", 32'(hit_length[56 +: 8]), 32'd9);
        tick();
        chk("free2_wr", 32'(wr_en), 32'h000080);
        chk("free2_q", 32'(hit_add_inQ[56 +: 8]), 32'h77);
        tick();
        chk("free_idle", 32'(wr_en), 32'h0);
        chk("free_dcount", 32'(dispatch_count), 32'd25);
        chk("free_scount", 32'(stall_count), 32'd4);

        // Zero-length hits are consumed silently
        lane_full = '0;
        drive(1'b1, 8'hEE, 8'hEF, 8'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("zero_rdy", 32'(in_ready), 32'h1);
            chk("zero_wr", 32'(wr_en), 32'h0);
        end
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        chk("zero_wr_after", 32'(wr_en), 32'h0);
        chk("zero_dcount", 32'(dispatch_count), 32'd25);
        chk("zero_scount", 32'(stall_count), 32'd4);

        // Reset with a wr_en pulse live and a hit held under all-full
        drive(1'b1, 8'h90, 8'h91, 8'd3);
        tick();
        drive(1'b1, 8'h99, 8'h9A, 8'd3);
        tick();
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        lane_full = '1;
        chk("rst6_pulse", 32'(wr_en), 32'h000100);
        #1;
        chk("rst6_held_rdy", 32'(in_ready), 32'h0);
        reset_n = 1'b0;
        #1;
        chk("rst6_wr_async", 32'(wr_en), 32'h0);
        chk("rst6_rdy", 32'(in_ready), 32'h1);
        chk("rst6_dcount", 32'(dispatch_count), 32'h0);
        tick();
        reset_n   = 1'b1;
        lane_full = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst6_no_wr", 32'(wr_en), 32'h0);
        end
        chk("rst6_dcount_after", 32'(dispatch_count), 32'h0);
        chk("rst6_scount_after", 32'(stall_count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hit_dispatcher.md
# hit_dispatcher

Round-robin distributor that feeds the per-lane hit FIFOs from a single serialized hit stream. It is the write side of the lane-FIFO interface whose read side is the round-robin hit collector. One hit per cycle (query address, subject address, hit length) arrives on a valid/ready port. Each hit is written into exactly one non-full lane FIFO via a one-hot `wr_en` pulse, with the lane pointer rotating so hits spread evenly across lanes.

## Interface
- `LENGTH_COUNTER`, 8: width of each address/length field.
- `LENGTH_HIT_INFO`, 22: number of lanes (lane FIFOs).
- `PTR_WIDTH`, 5: width of lane pointer; must satisfy 2^PTR_WIDTH >= LENGTH_HIT_INFO.
- `CNT_WIDTH`, 16: width of statistics counters.

Ports:
- `com_clk` input 1: single clock, all logic rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: input hit present.
- `in_ready` output 1: dispatcher accepts hit this cycle.
- `in_add_inQ` input LENGTH_COUNTER: query address of hit.
- `in_add_inS` input LENGTH_COUNTER: subject address of hit.
- `in_length` input LENGTH_COUNTER: hit length; 0 means "no hit".
- `lane_full` input LENGTH_HIT_INFO: per-lane FIFO full flags.
- `wr_en` output LENGTH_HIT_INFO: one-hot lane write strobe.
- `hit_add_inQ` output LENGTH_COUNTER*LENGTH_HIT_INFO: packed per-lane query address; lane j at bits [j*LENGTH_COUNTER +: LENGTH_COUNTER].
- `hit_add_inS` output LENGTH_COUNTER*LENGTH_HIT_INFO: packed per-lane subject address.
- `hit_length` output LENGTH_COUNTER*LENGTH_HIT_INFO: packed per-lane hit length.
- `dispatch_count` output CNT_WIDTH: hits written to lanes, saturating.
- `stall_count` output CNT_WIDTH: cycles a held hit found all lanes full, saturating.

## Operation
- **Holding register.**
  - One-entry holding register: `hold_valid`, Q, S, length.
  - `in_ready = !hold_valid || dispatch_now`.
- **Accept.** A handshake occurs when `in_valid && in_ready`.
  - If `in_length != 0`, the hit loads into the holding register.
  - If `in_length == 0`, the hit is consumed and discarded. No count, no write.
- **Lane select.** Combinational rotating-priority search over `~lane_full`, starting at `rr_ptr` and wrapping at LENGTH_HIT_INFO-1 -> 0. The result is `sel_found` and `sel_lane`.
- **Dispatch.** `dispatch_now = hold_valid && sel_found`. On that edge:
  - Register `wr_en = 1 << sel_lane`.
  - Drive all lane slices of the three data buses with the held hit. Data is broadcast; only `wr_en` selects the lane.
  - Set `rr_ptr <= (sel_lane == LENGTH_HIT_INFO-1) ? 0 : sel_lane+1`.
  - Increment `dispatch_count`.
- **Stall.** When `hold_valid && !sel_found`:
  - Hold the hit, drive `in_ready` low, keep `wr_en` at 0.
  - Increment `stall_count`.
- **States.**
  - EMPTY (`hold_valid=0`): goes to HELD on a non-zero accept.
  - HELD: goes to EMPTY on dispatch without a new accept; stays HELD on dispatch with a new accept, or on stall.
- `wr_en` has at most one bit set per cycle and is deasserted in every cycle without a dispatch.
- Counters saturate at all-ones; they do not wrap.

## Timing
- **Reset values:**
  - `wr_en` = 0; all data buses = 0; `rr_ptr` = 0; `hold_valid` = 0.
  - `dispatch_count` = 0; `stall_count` = 0.
  - `in_ready` = 1.
- **Latency:** a hit accepted at edge E0 appears with `wr_en` asserted for exactly one cycle after edge E1, provided some lane is free in the cycle between E0 and E1.
- **Throughput:** 1 hit/cycle sustained when a lane is free every cycle.
- **Sampling:** `lane_full` is sampled in the dispatch cycle. A lane that goes full that cycle is not written.
- **Simultaneous accept and dispatch:** the new hit loads into the holding register on the same edge the old hit dispatches.
- **All lanes full:** hold indefinitely. No hit is lost and none is duplicated.
- **Reset mid-operation:** the held hit is discarded, and any `wr_en` pulse is cleared asynchronously.
- **Data bus stability:** data buses keep their last value between dispatches; downstream qualifies them only with `wr_en`.

## Structure
- **Shared package `hit_pkg`:**
  - LENGTH_COUNTER and LENGTH_HIT_INFO constants.
  - A hit record type {Q, S, length}.
  - A lane-index type of PTR_WIDTH bits.
  - This package is shared with the hit collector.
- **Sub-module `rr_lane_select`:** purely combinational rotating-priority finder.
  - Inputs: `avail` vector, `rr_ptr`.
  - Outputs: `sel_found`, `sel_lane`.
  - Implementation: double-width vector technique or mask-then-fallback; no loops over time.
- **Top level:** holding register, pointer, output registers, counters.

## Test plan
- **Reset, all lanes free, 3 back-to-back hits** (Q=0x10/0x11/0x12, len=5) -> `wr_en` = 0x000001, 0x000002, 0x000004 on consecutive cycles; `dispatch_count` = 3; `in_ready` stays 1.
- **Skip full lanes:** lanes 0–3 full, `rr_ptr` = 0, one hit -> `wr_en` = 0x000010; next hit -> lane 5.
- **Wrap-around:** drive 23 hits with no lane full -> hit 22 goes to lane 21 (`wr_en` = 0x200000); hit 23 goes to lane 0.
- **All full for 4 cycles, then lane 7 frees:**
  - While all full: `in_ready` = 0 and `stall_count` increments by 4.
  - When lane 7 frees: exactly one `wr_en` = 0x000080 carrying the held hit's values.
- **Zero-length input** (`in_length` = 0, valid for 3 cycles) -> `in_ready` = 1, no `wr_en`, counters unchanged.
- **`reset_n` asserted while HELD under all-full** -> `wr_en` = 0 immediately. After release, the held hit is never written and `dispatch_count` = 0.
